// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Collects results from the add/sub/mul/div execution units into one
//   register-file writeback stream.
//   - alu_rc_hold: one-entry holding buffer per unit (ready = !full).
//   - alu_result_collector: round-robin arbiter over occupied buffers plus a
//     registered writeback stage with a valid/ready handshake.
// Ports (top):
//   clk, rst_n                 clock, async active-low reset
//   <u>_valid/_res/_rd         unit result handshake in (u = add,sub,mul,div)
//   <u>_ready                  holding buffer empty, can accept
//   wb_valid/_data/_rd/_opcode writeback entry (opcode = source unit index)
//   wb_ready                   register file accepts writeback
//   busy                       any buffer full or writeback pending

module alu_rc_hold #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_res_i,
  input  logic [TAG_W-1:0]  in_rd_i,
  output logic              in_ready_o,
  input  logic              clr_i,      // entry granted this cycle
  output logic              full_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]  rd_o
);
  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  rd_q;
  logic              take;

  // A full buffer never accepts, so grant-clear and capture never collide.
  assign take = in_valid_i && !full_q;

  always_comb begin
    full_d = full_q;
    if (take)       full_d = 1'b1;
    else if (clr_i) full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      full_q <= full_d;
      if (take) begin
        data_q <= in_res_i;
        rd_q   <= in_rd_i;
      end
    end
  end

  assign in_ready_o = !full_q;
  assign full_o     = full_q;
  assign data_o     = data_q;
  assign rd_o       = rd_q;
endmodule

module alu_result_collector #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add_valid,
  input  logic [DATA_W-1:0] add_res,
  input  logic [TAG_W-1:0]  add_rd,
  output logic              add_ready,
  input  logic              sub_valid,
  input  logic [DATA_W-1:0] sub_res,
  input  logic [TAG_W-1:0]  sub_rd,
  output logic              sub_ready,
  input  logic              mul_valid,
  input  logic [DATA_W-1:0] mul_res,
  input  logic [TAG_W-1:0]  mul_rd,
  output logic              mul_ready,
  input  logic              div_valid,
  input  logic [DATA_W-1:0] div_res,
  input  logic [TAG_W-1:0]  div_rd,
  output logic              div_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [TAG_W-1:0]  wb_rd,
  output logic [1:0]        wb_opcode,
  input  logic              wb_ready,
  output logic              busy
);
  localparam int NUM_SRC = 4;

  logic [NUM_SRC-1:0]             src_valid, src_ready, full, clr;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_res, buf_data;
  logic [NUM_SRC-1:0][TAG_W-1:0]  src_rd, buf_rd;

  assign src_valid = {div_valid, mul_valid, sub_valid, add_valid};
  assign src_res   = {div_res, mul_res, sub_res, add_res};
  assign src_rd    = {div_rd, mul_rd, sub_rd, add_rd};
  assign {div_ready, mul_ready, sub_ready, add_ready} = src_ready;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_hold
    alu_rc_hold #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (src_valid[s]),
      .in_res_i   (src_res[s]),
      .in_rd_i    (src_rd[s]),
      .in_ready_o (src_ready[s]),
      .clr_i      (clr[s]),
      .full_o     (full[s]),
      .data_o     (buf_data[s]),
      .rd_o       (buf_rd[s])
    );
  end

  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [TAG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [1:0]        wb_op_q, wb_op_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              ld, gnt;
  logic [1:0]        gnt_idx, idx;

  // Output register may load when empty or draining this cycle.
  assign ld = !wb_valid_q || wb_ready;

  // First full buffer scanning circularly from rr_ptr.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = rr_ptr_q;
    idx     = rr_ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!gnt && full[idx]) begin
        gnt     = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt = gnt && ld;
  end

  always_comb begin
    clr = '0;
    if (gnt) clr[gnt_idx] = 1'b1;
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_op_d    = wb_op_q;
    rr_ptr_d   = rr_ptr_q;
    if (gnt) begin
      wb_valid_d = 1'b1;
      wb_data_d  = buf_data[gnt_idx];
      wb_rd_d    = buf_rd[gnt_idx];
      wb_op_d    = gnt_idx;
      rr_ptr_d   = gnt_idx + 2'd1;
    end else if (ld) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_op_q    <= 2'd0;
      rr_ptr_q   <= 2'd0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_op_q    <= wb_op_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign wb_opcode = wb_op_q;
  assign busy      = (|full) || wb_valid_q;
endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: a behavioural model pushes each
// expected writeback into a queue at grant time; a monitor pops and compares
// on every writeback transfer and also checks readys/busy/wb_* each cycle.
module tb_alu_result_collector;
  localparam int DW = 16;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]         vld;
  logic [3:0][DW-1:0] res;
  logic [3:0][TW-1:0] rdv;
  logic               wb_ready;
  logic [3:0]         rdy;
  logic               wb_valid, busy;
  logic [DW-1:0]      wb_data;
  logic [TW-1:0]      wb_rd;
  logic [1:0]         wb_opcode;

  alu_result_collector #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .add_valid(vld[0]), .add_res(res[0]), .add_rd(rdv[0]), .add_ready(rdy[0]),
    .sub_valid(vld[1]), .sub_res(res[1]), .sub_rd(rdv[1]), .sub_ready(rdy[1]),
    .mul_valid(vld[2]), .mul_res(res[2]), .mul_rd(rdv[2]), .mul_ready(rdy[2]),
    .div_valid(vld[3]), .div_res(res[3]), .div_rd(rdv[3]), .div_ready(rdy[3]),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_opcode(wb_opcode),
    .wb_ready(wb_ready), .busy(busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] r;
    logic [1:0]    op;
  } wb_t;

  wb_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  bit            m_full[4];
  logic [DW-1:0] m_data[4];
  logic [TW-1:0] m_rd[4];
  int            m_ptr;
  bit            m_wbv;
  wb_t           m_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_full[s] = 0; m_data[s] = '0; m_rd[s] = '0;
    end
    m_ptr = 0; m_wbv = 0; m_cur = '0;
    exp_q.delete();
  endtask

  // One clock edge of behaviour, using the inputs presented at that edge.
  task automatic model_step();
    bit acc[4];
    bit found;
    int g;
    found = 0; g = 0;
    for (int s = 0; s < 4; s++) acc[s] = vld[s] && !m_full[s];
    if (!m_wbv || wb_ready) begin
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (m_ptr + k) % 4;
        if (!found && m_full[s]) begin found = 1; g = s; end
      end
      if (found) begin
        m_wbv = 1;
        m_cur.d = m_data[g]; m_cur.r = m_rd[g]; m_cur.op = 2'(g);
        exp_q.push_back(m_cur);
        m_full[g] = 0;
        m_ptr = (g + 1) % 4;
      end else begin
        m_wbv = 0;
      end
    end
    for (int s = 0; s < 4; s++)
      if (acc[s]) begin
        m_full[s] = 1; m_data[s] = res[s]; m_rd[s] = rdv[s];
      end
  endtask

  // Monitor: per-cycle state checks and scoreboard pop on transfer.
  always @(negedge clk) begin : mon
    wb_t e;
    logic [3:0] exp_rdy;
    if (rst_n) begin
      exp_rdy = {!m_full[3], !m_full[2], !m_full[1], !m_full[0]};
      chk("readys", 32'(rdy), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_full[0] || m_full[1] || m_full[2] || m_full[3] || m_wbv));
      chk("wb_valid", 32'(wb_valid), 32'(m_wbv));
      if (m_wbv) begin
        chk("wb_hold", 32'({wb_data, wb_rd, wb_opcode}), 32'(m_cur));
      end
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wb: got data=%0h rd=%0h op=%0d expected none", wb_data, wb_rd, wb_opcode);
        end else begin
          e = exp_q.pop_front();
          chk("wb_data", 32'(wb_data), 32'(e.d));
          chk("wb_rd", 32'(wb_rd), 32'(e.r));
          chk("wb_opcode", 32'(wb_opcode), 32'(e.op));
        end
      end
    end
  end

  task automatic step(input logic [3:0] v, input logic wbr);
    vld = v; wb_ready = wbr;
    @(posedge clk);
    model_step();
    #1;
    vld = '0;
  endtask

  task automatic rand_src();
    for (int s = 0; s < 4; s++) begin
      res[s] = 16'($urandom);
      rdv[s] = 4'($urandom);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'h0);
    chk({tag, "_wb_data"}, 32'(wb_data), 32'h0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'h0);
    chk({tag, "_wb_opcode"}, 32'(wb_opcode), 32'h0);
    chk({tag, "_readys"}, 32'(rdy), 32'hf);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; vld = '0; res = '0; rdv = '0; wb_ready = 1'b1;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single add
    res[0] = 16'h0034; rdv[0] = 4'd3;
    step(4'b0001, 1'b1);
    repeat (4) step(4'b0000, 1'b1);

    // Four simultaneous
    for (int s = 0; s < 4; s++) begin res[s] = 16'(s + 1); rdv[s] = 4'(s + 1); end
    step(4'b1111, 1'b1);
    repeat (6) step(4'b0000, 1'b1);

    // Fairness: after div grant, add before mul; after sub grant, mul before add
    rand_src(); step(4'b0101, 1'b1);
    repeat (4) step(4'b0000, 1'b1);
    rand_src(); step(4'b0010, 1'b1);
    repeat (3) step(4'b0000, 1'b1);
    rand_src(); step(4'b0101, 1'b1);
    repeat (4) step(4'b0000, 1'b1);

    // Backpressure with 00AA held
    res[0] = 16'h00AA; rdv[0] = 4'd7;
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    rand_src(); step(4'b0110, 1'b0);
    repeat (3) begin rand_src(); step(4'b0110, 1'b0); end
    repeat (5) step(4'b0000, 1'b1);

    // Ignored second mul valid
    rand_src(); step(4'b0100, 1'b1);
    rand_src(); step(4'b0100, 1'b1);
    repeat (4) step(4'b0000, 1'b1);

    // Reset mid-operation: two buffers full, wb_valid high
    rand_src(); step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    rand_src(); step(4'b0110, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) step(4'b0000, 1'b1);

    // Random traffic
    repeat (400) begin
      rand_src();
      step(4'($urandom), ($urandom % 4) != 0);
    end
    repeat (12) step(4'b0000, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
